// File: rtl/iob_clkmux_ctrl_pkg.sv
// Shared types and helpers for the clock-mux switch sequencer.
package iob_clkmux_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StLock   = 3'd1,
      StOff    = 3'd2,
      StSettle = 3'd3,
      StAck    = 3'd4
   } state_e;

   // Counter width large enough to hold the longest of the three timed phases.
   function automatic int unsigned cnt_width(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/iob_clkmux_ctrl_cnt.sv
// Loadable saturating down-counter with zero flag; times the OFF, SETTLE and LOCK phases.
module iob_clkmux_ctrl_cnt #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/iob_clkmux_ctrl.sv
// Switch sequencer for a 2-input clock mux: gate clock off, move select, settle, re-enable, ack.
// Optional lock wait before switching is enabled by defining IOB_CLKMUX_CTRL_LOCK_EN.
module iob_clkmux_ctrl
   import iob_clkmux_ctrl_pkg::*;
#(
   parameter bit          INIT_SEL      = 1'b0,
   parameter int unsigned OFF_CYCLES    = 4,
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter int unsigned LOCK_TIMEOUT  = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic sw_req_i,
   input  logic sw_sel_i,
   output logic sw_ack_o,
   output logic sw_err_o,
   output logic busy_o,
   output logic clk_sel_o,
   output logic clk_en_o
`ifdef IOB_CLKMUX_CTRL_LOCK_EN
   ,
   input  logic lock_i
`endif
);

   localparam int unsigned CntW = cnt_width(OFF_CYCLES, SETTLE_CYCLES, LOCK_TIMEOUT);

   state_e state_q, state_d;
   logic   target_q, target_d;
   logic   sel_q, sel_d;
   logic   en_q, en_d;
   logic   ack_q, ack_d;
   logic   err_q, err_d;
   logic   busy_q, busy_d;

   logic            cnt_load;
   logic [CntW-1:0] cnt_val;
   logic            cnt_zero;

   iob_clkmux_ctrl_cnt #(
      .W(CntW)
   ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .load_i    (cnt_load),
      .load_val_i(cnt_val),
      .zero_o    (cnt_zero)
   );

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      sel_d    = sel_q;
      en_d     = en_q;
      err_d    = 1'b0;
      cnt_load = 1'b0;
      cnt_val  = '0;

      unique case (state_q)
         StIdle: begin
            if (sw_req_i) begin
               target_d = sw_sel_i;
               if (sw_sel_i == sel_q) begin
                  state_d = StAck;
               end else begin
`ifdef IOB_CLKMUX_CTRL_LOCK_EN
                  state_d  = StLock;
                  cnt_load = 1'b1;
                  cnt_val  = CntW'(LOCK_TIMEOUT - 1);
`else
                  state_d  = StOff;
                  en_d     = 1'b0;
                  cnt_load = 1'b1;
                  cnt_val  = CntW'(OFF_CYCLES - 1);
`endif
               end
            end
         end

         StLock: begin
`ifdef IOB_CLKMUX_CTRL_LOCK_EN
            // Clock keeps running on the old source until the new one reports lock.
            if (lock_i) begin
               state_d  = StOff;
               en_d     = 1'b0;
               cnt_load = 1'b1;
               cnt_val  = CntW'(OFF_CYCLES - 1);
            end else if (cnt_zero) begin
               state_d = StAck;
               err_d   = 1'b1;
            end
`else
            state_d = StIdle;
`endif
         end

         StOff: begin
            if (cnt_zero) begin
               sel_d    = target_q;
               state_d  = StSettle;
               cnt_load = 1'b1;
               cnt_val  = CntW'(SETTLE_CYCLES - 1);
            end
         end

         StSettle: begin
            if (cnt_zero) begin
               en_d    = 1'b1;
               state_d = StAck;
            end
         end

         StAck: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // Outputs are registered from the next state so they line up with the state register.
      ack_d  = (state_d == StAck);
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         target_q <= INIT_SEL;
         sel_q    <= INIT_SEL;
         en_q     <= 1'b1;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         sel_q    <= sel_d;
         en_q     <= en_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
      end
   end

   assign sw_ack_o  = ack_q;
   assign sw_err_o  = err_q;
   assign busy_o    = busy_q;
   assign clk_sel_o = sel_q;
   assign clk_en_o  = en_q;

endmodule

// File: tb/tb_iob_clkmux_ctrl.sv
// Self-checking bench for iob_clkmux_ctrl: vector table plus ack scoreboard and corner sequences.
module tb_iob_clkmux_ctrl;

   localparam int OFF    = 4;
   localparam int SETTLE = 8;
   localparam int LTO    = 16;
`ifdef IOB_CLKMUX_CTRL_LOCK_EN
   localparam int D = 1;
`else
   localparam int D = 0;
`endif
   localparam int DL = 1 + OFF + SETTLE + D;

   logic clk, rst, sw_req_i, sw_sel_i;
   logic sw_ack_o, sw_err_o, busy_o, clk_sel_o, clk_en_o;
`ifdef IOB_CLKMUX_CTRL_LOCK_EN
   logic lock_i;
`endif

   iob_clkmux_ctrl #(
      .INIT_SEL     (1'b0),
      .OFF_CYCLES   (OFF),
      .SETTLE_CYCLES(SETTLE),
      .LOCK_TIMEOUT (LTO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .sw_req_i (sw_req_i),
      .sw_sel_i (sw_sel_i),
      .sw_ack_o (sw_ack_o),
      .sw_err_o (sw_err_o),
      .busy_o   (busy_o),
      .clk_sel_o(clk_sel_o),
      .clk_en_o (clk_en_o)
`ifdef IOB_CLKMUX_CTRL_LOCK_EN
      ,
      .lock_i   (lock_i)
`endif
   );

   typedef struct {
      logic sel;
      int   lat;
      logic xsel;
      int   enlow;
   } vec_t;

   typedef struct {
      int   cyc;
      logic sel;
      logic err;
      int   enlow;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   enlow_cnt = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // One cycle: drop any request pulse, then check busy/ack/err against the scoreboard.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      sw_req_i = 1'b0;
      chk("busy", int'(busy_o), int'(q.size() != 0));
      chk("spurious_ack", int'(sw_ack_o && q.size() == 0), 0);
      chk("err_without_ack", int'(sw_err_o && !sw_ack_o), 0);
      if (sw_ack_o && q.size() != 0) begin
         e = q.pop_front();
         chk("ack_cycle", cyc, e.cyc);
         chk("ack_sel", int'(clk_sel_o), int'(e.sel));
         chk("ack_err", int'(sw_err_o), int'(e.err));
         chk("en_low_cycles", enlow_cnt, e.enlow);
         enlow_cnt = 0;
      end else if (!clk_en_o) begin
         enlow_cnt++;
      end
   endtask

   task automatic issue(input logic sel, input int lat, input logic xsel, input logic xerr,
                        input int enlow);
      exp_t e;
      tick();
      sw_req_i = 1'b1;
      sw_sel_i = sel;
      e.cyc    = cyc + lat;
      e.sel    = xsel;
      e.err    = xerr;
      e.enlow  = enlow;
      q.push_back(e);
   endtask

   task automatic wait_ack();
      for (int i = 0; i < 200 && q.size() != 0; i++) tick();
      chk("ack_timeout", q.size(), 0);
      q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      q.delete();
      enlow_cnt = 0;
      tick();
      rst = 1'b0;
   endtask

   vec_t vecs[7];
   int   n0;

   initial begin
      vecs[0] = '{sel: 1'b0, lat: 1,  xsel: 1'b0, enlow: 0};
      vecs[1] = '{sel: 1'b1, lat: DL, xsel: 1'b1, enlow: OFF + SETTLE};
      vecs[2] = '{sel: 1'b1, lat: 1,  xsel: 1'b1, enlow: 0};
      vecs[3] = '{sel: 1'b0, lat: DL, xsel: 1'b0, enlow: OFF + SETTLE};
      vecs[4] = '{sel: 1'b0, lat: 1,  xsel: 1'b0, enlow: 0};
      vecs[5] = '{sel: 1'b1, lat: DL, xsel: 1'b1, enlow: OFF + SETTLE};
      vecs[6] = '{sel: 1'b0, lat: DL, xsel: 1'b0, enlow: OFF + SETTLE};

      sw_req_i = 1'b0;
      sw_sel_i = 1'b0;
`ifdef IOB_CLKMUX_CTRL_LOCK_EN
      lock_i = 1'b1;
`endif
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state.
      tick();
      chk("rst_sel", int'(clk_sel_o), 0);
      chk("rst_en", int'(clk_en_o), 1);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_ack", int'(sw_ack_o), 0);

      // Vector table: back-to-back requests, next one issued the cycle after each ack.
      foreach (vecs[i]) begin
         issue(vecs[i].sel, vecs[i].lat, vecs[i].xsel, 1'b0, vecs[i].enlow);
         wait_ack();
         chk("table_final_sel", int'(clk_sel_o), int'(vecs[i].xsel));
      end

      // Full switch timing, with a request during busy that must be dropped.
      issue(1'b1, DL, 1'b1, 1'b0, OFF + SETTLE);
      n0 = cyc;
      for (int i = 1; i <= DL; i++) begin
         tick();
         chk("seq_en", int'(clk_en_o), int'(i <= D || i >= DL));
         chk("seq_sel", int'(clk_sel_o), int'(i >= OFF + 1 + D));
         if (i == 2) begin
            sw_req_i = 1'b1;
            sw_sel_i = 1'b0;
         end
      end
      chk("seq_queue_empty", q.size(), 0);
      repeat (DL + 4) tick();
      chk("ignored_req_sel", int'(clk_sel_o), 1);

      // Reset from sel=1 returns to INIT_SEL.
      do_reset();
      chk("rst2_sel", int'(clk_sel_o), 0);

      // Reset mid-sequence: abort with no ack.
      issue(1'b1, DL, 1'b1, 1'b0, OFF + SETTLE);
      n0 = cyc;
      repeat (6) tick();
      rst = 1'b1;
      q.delete();
      enlow_cnt = 0;
      tick();
      rst = 1'b0;
      chk("abort_cycle", cyc - n0, 7);
      chk("abort_sel", int'(clk_sel_o), 0);
      chk("abort_en", int'(clk_en_o), 1);
      chk("abort_busy", int'(busy_o), 0);
      chk("abort_ack", int'(sw_ack_o), 0);
      repeat (20) tick();
      chk("abort_sel_after", int'(clk_sel_o), 0);

`ifdef IOB_CLKMUX_CTRL_LOCK_EN
      // Lock never arrives: timeout ack with error, clock untouched.
      lock_i = 1'b0;
      issue(1'b1, LTO + 1, 1'b0, 1'b1, 0);
      wait_ack();
      chk("timeout_sel", int'(clk_sel_o), 0);

      // Lock arrives late: switch proceeds once it is seen.
      issue(1'b1, 7 + OFF + SETTLE, 1'b1, 1'b0, OFF + SETTLE);
      repeat (6) tick();
      lock_i = 1'b1;
      wait_ack();
      chk("late_lock_sel", int'(clk_sel_o), 1);
`endif

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
